ringosc_freqmeter: RTL and testbench
====================================

# ringosc_freqmeter

Parametrised multi-channel frequency meter for on-chip ring oscillators. It enables a masked set of oscillators, waits a settle time, then counts rising edges of every channel in parallel over a fixed gate window of `clk` cycles. Results are emitted one channel at a time on a valid/ready stream. It replaces the single free-running counter on one oscillator tap and feeds the host readout/LED logic in the top level.

## Interface
- `CHANNELS`, 5: number of oscillator inputs/enables.
- `CNT_W`, 24: width of each edge count; saturating.
- `GATE_CYCLES`, 1000000: gate window length in `clk` cycles, ≥1.
- `SETTLE_CYCLES`, 1024: wait after enabling oscillators before gating, ≥0.

- `clk`  in  1: system clock; sole clock of the block.
- `rst_n`  in  1: asynchronous, active-low reset.
- `osc_in`  in  CHANNELS: raw oscillator taps, asynchronous to `clk`.
- `osc_en`  out  CHANNELS: per-channel oscillator enable to the ring gate.
- `chan_mask`  in  CHANNELS: channels to run; sampled on accepted `start`.
- `start`  in  1: begin a measurement; accepted only in IDLE.
- `continuous`  in  1: sampled on accepted `start` and at end of each DRAIN.
- `busy`  out  1: high in every state except IDLE.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts result when `res_valid & res_ready`.
- `res_chan`  out  clog2(CHANNELS): channel index of current result.
- `res_count`  out  CNT_W: rising edges counted in the window.
- `res_ovf`  out  1: count saturated during the window.

## Operation
- Reset values: state IDLE; `osc_en`=0, `busy`=0, `res_valid`=0, `res_chan`=0, `res_count`=0, `res_ovf`=0; all counters and snapshots 0.
- States: IDLE → SETTLE → GATE → DRAIN → (GATE if continuous, else IDLE).
- IDLE: `start`=1 latches `chan_mask` and `continuous`, goes to SETTLE (or straight to GATE when `SETTLE_CYCLES`=0).
- SETTLE: `osc_en`=latched mask; after `SETTLE_CYCLES` cycles → GATE.
- GATE: per-channel counters cleared on entry; for `GATE_CYCLES` cycles each cycle with a synchronised rising edge on an enabled channel increments that counter. At all-ones the counter holds and sets its ovf flag. Masked channels count nothing.
- End of GATE: counts and ovf flags copied to the snapshot registers; → DRAIN.
- DRAIN: presents channels 0..CHANNELS-1 in order, masked channels included with count 0. `res_*` is stable while `res_valid & !res_ready`. On the final channel's handshake: if `continuous`=1 → GATE, else → IDLE.
- `osc_en`=latched mask in SETTLE and GATE, and in DRAIN only when continuous; otherwise 0.
- Edges during DRAIN are not counted; this dead time is accepted.
- `start` while busy is ignored; `chan_mask` changes while busy are ignored.
- `rst_n` low in any state returns immediately to reset values; any partial result is discarded.

## Timing
- Synchroniser: 2 flops per channel, plus a third for edge detect. An edge is counted 3 cycles after it arrives; cycles are aligned to the gate boundaries after synchronisation.
- Measurable rate ≤ f_clk/2 (input high and low each ≥1 `clk` period); faster inputs alias.
- With `start` accepted at cycle t: `busy`=1 from t+1; GATE from t+1+SETTLE_CYCLES; first `res_valid` at t+1+SETTLE_CYCLES+GATE_CYCLES.
- With `res_ready` held high: one result per cycle.
- Continuous mode: the next GATE begins the cycle after the final handshake, with no SETTLE.
- Width rule: the count is the exact edge number when ≤ 2^CNT_W−1, otherwise 2^CNT_W−1 with `res_ovf`=1.

## Structure
- Shared package `ringosc_pkg`: state encoding (IDLE/SETTLE/GATE/DRAIN) and a `clog2` helper for counter and channel widths.
- One natural sub-module, `ringosc_edge_counter`: synchroniser, edge detect, and saturating counter with clear/enable/ovf. It is instantiated CHANNELS times; the FSM, gate/settle timers and drain mux stay in the top module.

## Test plan
- CHANNELS=3, CNT_W=8, GATE=100, SETTLE=4, mask=111; ch0 period 4 clk, ch1 period 10, ch2 held low → results (0,25,0),(1,10,0),(2,0,0); first `res_valid` exactly 105 cycles after `start`.
- CNT_W=4, ch0 period 2 clk (50 edges) → `res_count`=15, `res_ovf`=1; the other channels are unaffected.
- `res_ready` low for 20 cycles during DRAIN → `res_valid` stays 1 and `res_chan`/`res_count` are stable; no result is lost or duplicated.
- `continuous`=1 → two windows run back-to-back, and the second GATE starts the cycle after the ch2 handshake with `osc_en` held. Drop `continuous` → IDLE after the next DRAIN, then `osc_en`=0 and `busy`=0.
- `rst_n` pulsed low mid-GATE → `busy`, `osc_en` and `res_valid` go to 0 asynchronously. A fresh `start` then yields the correct counts with no residue.
- mask=101 → `osc_en`=101 and ch1 reports count 0. A `start` pulse during GATE is ignored, and the result sequence is unchanged.

Source files
------------

// File: rtl/ringosc_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: FSM state
// encoding and constant width helpers used by the top, sub-module and interface.
package ringosc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  // Ceiling log2, never below 1 so a single-channel build still has a legal index.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ringosc_freqmeter_if.sv
// Result stream of the frequency meter: one channel result per valid/ready handshake.
interface ringosc_freqmeter_if
  import ringosc_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int CNT_W    = 24
);

  localparam int CH_W = clog2(CHANNELS);

  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_chan;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;

  modport master (
    output res_valid,
    output res_chan,
    output res_count,
    output res_ovf,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_chan,
    input  res_count,
    input  res_ovf,
    output res_ready
  );

endinterface

// File: rtl/ringosc_edge_counter.sv
// One oscillator channel: two-flop synchroniser, rising-edge detect and a
// saturating edge counter. Exposes next-cycle values so a snapshot can be taken
// on the same edge that performs the final increment of a window.
module ringosc_edge_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count_d,
  output logic             ovf_d
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       sync_q;
  logic             rise;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], osc};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (enable && rise) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/ringosc_freqmeter.sv
// Multi-channel ring-oscillator frequency meter: enable masked oscillators,
// settle, count edges of all channels over a fixed gate, then stream results.
module ringosc_freqmeter
  import ringosc_pkg::*;
#(
  parameter int CHANNELS      = 5,
  parameter int CNT_W         = 24,
  parameter int GATE_CYCLES   = 1000000,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] osc_in,
  output logic [CHANNELS-1:0] osc_en,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic                start,
  input  logic                continuous,
  output logic                busy,
  ringosc_freqmeter_if.master res
);

  localparam int CH_W  = clog2(CHANNELS);
  localparam int TMR_W = clog2(max2(GATE_CYCLES, SETTLE_CYCLES) + 1);

  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CH_W-1:0]  LAST_CHAN   = CH_W'(CHANNELS - 1);

  state_e              state;
  state_e              next_state;
  logic [TMR_W-1:0]    timer;
  logic [CH_W-1:0]     drain_idx;
  logic [CHANNELS-1:0] mask_q;
  logic                cont_q;

  logic                res_fire;
  logic                last_fire;
  logic                cnt_clear;
  logic                cnt_run;
  logic                capture;

  logic [CNT_W-1:0]    cnt_next [CHANNELS];
  logic [CHANNELS-1:0] ovf_next;
  logic [CNT_W-1:0]    snap_count [CHANNELS];
  logic [CHANNELS-1:0] snap_ovf;

  // Handshake is decoded from the state register, keeping next_state free of output feedback.
  assign res_fire  = (state == ST_DRAIN) && res.res_ready;
  assign last_fire = res_fire && (drain_idx == LAST_CHAN);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    ringosc_edge_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .osc    (osc_in[i]),
      .clear  (cnt_clear),
      .enable (cnt_run & mask_q[i]),
      .count_d(cnt_next[i]),
      .ovf_d  (ovf_next[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = (SETTLE_CYCLES == 0) ? ST_GATE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer == SETTLE_LAST) next_state = ST_GATE;
      end
      ST_GATE: begin
        if (timer == GATE_LAST) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_fire) next_state = continuous ? ST_GATE : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != ST_IDLE);
    res.res_valid = (state == ST_DRAIN);
    res.res_chan  = drain_idx;
    res.res_count = snap_count[drain_idx];
    res.res_ovf   = snap_ovf[drain_idx];
    osc_en        = '0;
    if ((state == ST_SETTLE) || (state == ST_GATE) || ((state == ST_DRAIN) && cont_q)) begin
      osc_en = mask_q;
    end
    cnt_clear = (next_state == ST_GATE) && (state != ST_GATE);
    cnt_run   = (state == ST_GATE);
    capture   = (state == ST_GATE) && (next_state == ST_DRAIN);
  end

  // The settle and gate timers share one counter, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state != next_state) begin
      timer <= '0;
    end else if ((state == ST_SETTLE) || (state == ST_GATE)) begin
      timer <= timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      cont_q <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      mask_q <= chan_mask;
      cont_q <= continuous;
    end else if (last_fire) begin
      cont_q <= continuous;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_idx <= '0;
    end else if (res_fire) begin
      drain_idx <= (drain_idx == LAST_CHAN) ? '0 : drain_idx + CH_W'(1);
    end
  end

  // NOTE: the snapshot array is small and its reset value is visible on res_count, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) snap_count[i] <= '0;
      snap_ovf <= '0;
    end else if (capture) begin
      for (int i = 0; i < CHANNELS; i++) snap_count[i] <= cnt_next[i];
      snap_ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_ringosc_freqmeter.sv
// Self-checking bench for ringosc_freqmeter: table-driven measurement runs with a
// result scoreboard, plus back-pressure, mid-gate reset and continuous-mode sequences.
module tb_ringosc_freqmeter;

  localparam int CH     = 3;
  localparam int CW     = 5;
  localparam int GATE   = 100;
  localparam int SETTLE = 4;
  localparam int LAT    = 1 + SETTLE + GATE;

  typedef struct {
    logic [CH-1:0]         mask;
    logic [CH-1:0][7:0]    per;
    logic [CH-1:0][CW-1:0] cnt;
    logic [CH-1:0]         ovf;
    bit                    poke;
  } vec_t;

  typedef struct packed {
    logic [1:0]    chan;
    logic [CW-1:0] cnt;
    logic          ovf;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] osc_in = '0;
  logic [CH-1:0] osc_en;
  logic [CH-1:0] chan_mask;
  logic          start;
  logic          continuous;
  logic          busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   period [CH] = '{0, 0, 0};
  vec_t vecs [4];
  res_t exp_q [$];

  ringosc_freqmeter_if #(.CHANNELS(CH), .CNT_W(CW)) res_if ();

  ringosc_freqmeter #(
    .CHANNELS     (CH),
    .CNT_W        (CW),
    .GATE_CYCLES  (GATE),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .osc_in    (osc_in),
    .osc_en    (osc_en),
    .chan_mask (chan_mask),
    .start     (start),
    .continuous(continuous),
    .busy      (busy),
    .res       (res_if)
  );

  always #5 clk = ~clk;

  // Free-running square waves, phase-locked to clk so periods dividing GATE give exact counts.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < CH; i++) begin
      osc_in[i] = (period[i] != 0) && ((cyc % period[i]) < (period[i] / 2));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_periods(input logic [CH-1:0][7:0] per);
    for (int i = 0; i < CH; i++) period[i] = int'(per[i]);
    repeat (10) @(negedge clk);
  endtask

  task automatic push_expected(input vec_t v);
    res_t e;
    for (int i = 0; i < CH; i++) begin
      e.chan = 2'(i);
      e.cnt  = v.cnt[i];
      e.ovf  = v.ovf[i];
      exp_q.push_back(e);
    end
  endtask

  // Starts a run at the current negedge and waits for the first result.
  task automatic start_and_wait(input vec_t v, input logic cont);
    int k;
    chan_mask  = v.mask;
    continuous = cont;
    start      = 1'b1;
    k          = 0;
    while (!res_if.res_valid && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        check("busy_after_start", busy, 1);
      end
      if (k == 60) begin
        check("osc_en_in_gate", osc_en, v.mask);
        if (v.poke) begin
          start     = 1'b1;
          chan_mask = ~v.mask;
        end
      end
      if (k == 61) begin
        start     = 1'b0;
        chan_mask = v.mask;
      end
    end
    check("first_valid_latency", k, LAT);
  endtask

  // Consumes n results; returns on the negedge before the final handshake edge.
  task automatic drain(input int n, input int stall);
    int            got;
    int            cyc_n;
    int            first_hs;
    int            last_hs;
    bit            stable;
    logic [1:0]    c0;
    logic [CW-1:0] n0;
    res_t          e;
    got      = 0;
    cyc_n    = 0;
    first_hs = 0;
    last_hs  = 0;
    stable   = 1'b1;
    c0       = res_if.res_chan;
    n0       = res_if.res_count;
    while (got < n && cyc_n < 1000) begin
      res_if.res_ready = (cyc_n >= stall);
      if (!res_if.res_ready) begin
        if (!res_if.res_valid || res_if.res_chan != c0 || res_if.res_count != n0) stable = 1'b0;
      end else if (res_if.res_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got chan %0d expected none", res_if.res_chan);
        end else begin
          e = exp_q.pop_front();
          check("res_chan", res_if.res_chan, e.chan);
          check("res_count", res_if.res_count, e.cnt);
          check("res_ovf", res_if.res_ovf, e.ovf);
        end
        if (got == 0) first_hs = cyc_n;
        last_hs = cyc_n;
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        cyc_n++;
      end
    end
    if (got < n) check("drain_timeout", got, n);
    if (stall > 0) check("stall_stable", stable, 1);
    check("one_per_cycle", last_hs - first_hs, n - 1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    res_if.res_ready = 1'b0;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_osc_en"}, osc_en, 0);
    check({tag, "_valid"}, res_if.res_valid, 0);
  endtask

  initial begin
    rst_n            = 1'b0;
    start            = 1'b0;
    continuous       = 1'b0;
    chan_mask        = '0;
    res_if.res_ready = 1'b0;

    vecs[0] = '{mask: 3'b111, per: {8'd0, 8'd10, 8'd4},
                cnt: {5'd0, 5'd10, 5'd25}, ovf: 3'b000, poke: 1'b0};
    vecs[1] = '{mask: 3'b111, per: {8'd4, 8'd10, 8'd2},
                cnt: {5'd25, 5'd10, 5'd31}, ovf: 3'b001, poke: 1'b0};
    vecs[2] = '{mask: 3'b101, per: {8'd10, 8'd10, 8'd4},
                cnt: {5'd10, 5'd0, 5'd25}, ovf: 3'b000, poke: 1'b1};
    vecs[3] = '{mask: 3'b010, per: {8'd2, 8'd20, 8'd4},
                cnt: {5'd0, 5'd5, 5'd0}, ovf: 3'b000, poke: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_osc_en", osc_en, 0);
    check("rst_valid", res_if.res_valid, 0);
    check("rst_chan", res_if.res_chan, 0);
    check("rst_count", res_if.res_count, 0);
    check("rst_ovf", res_if.res_ovf, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      apply_periods(vecs[i].per);
      push_expected(vecs[i]);
      start_and_wait(vecs[i], 1'b0);
      drain(CH, 0);
      check_idle("table_idle");
    end

    // Back-pressure: ready held low for 20 cycles at the start of DRAIN.
    apply_periods(vecs[0].per);
    push_expected(vecs[0]);
    start_and_wait(vecs[0], 1'b0);
    drain(CH, 20);
    check_idle("stall_idle");

    // Asynchronous reset in the middle of a gate window, then a fresh run.
    apply_periods(vecs[1].per);
    chan_mask = 3'b111;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_osc_en", osc_en, 0);
    check("async_rst_valid", res_if.res_valid, 0);
    check("async_rst_count", res_if.res_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_expected(vecs[1]);
    start_and_wait(vecs[1], 1'b0);
    drain(CH, 0);
    check_idle("post_rst_idle");

    // Continuous mode: two back-to-back windows, then drop continuous.
    apply_periods(vecs[0].per);
    push_expected(vecs[0]);
    push_expected(vecs[0]);
    start_and_wait(vecs[0], 1'b1);
    drain(CH, 0);
    check("cont_osc_en_drain", osc_en, 3'b111);
    @(negedge clk);
    check("cont_busy", busy, 1);
    check("cont_osc_en_gate", osc_en, 3'b111);
    check("cont_valid_low", res_if.res_valid, 0);
    continuous = 1'b0;
    begin
      int k;
      k = 0;
      while (!res_if.res_valid && k < 400) begin
        @(negedge clk);
        k++;
      end
      check("cont_second_latency", k, GATE);
    end
    drain(CH, 0);
    check_idle("cont_idle");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
